// File: rtl/display_pkg.sv
// Shared types and helpers for the four-digit seven-segment scan controller.
// Used by display_scan_ctrl and scan_slot_timer.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIB_W;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } scan_state_t;

  // One-hot-low anode pattern that lights only digit idx.
  function automatic logic [NUM_DIGITS-1:0] anode_decode(input digit_t idx);
    logic [NUM_DIGITS-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot timer: counts 0..SLOT_CYC-1, flags the leading blank guard
// band and strobes the last cycle of the slot. Held at zero while disabled.
module scan_slot_timer
  import display_pkg::*;
#(
  parameter int SLOT_CYC  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          i_en,
  output logic [cnt_width(SLOT_CYC)-1:0] o_cnt,
  output logic                          o_in_blank,
  output logic                          o_slot_last
);

  localparam int CNT_W = cnt_width(SLOT_CYC);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_in_blank  = (r_cnt < CNT_W'(BLANK_CYC));
  assign o_slot_last = (r_cnt == CNT_W'(SLOT_CYC - 1));

  // Slot counter: wraps at the end of each slot, parked at zero when disabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    if (res) begin
      r_cnt <= '0;
    end else if (!i_en || o_slot_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Refresh scheduler for a 4-digit multiplexed seven-segment display.
// Drives active-low anodes, digit index and nibble of the lit digit, with a
// blank guard band at the start of each slot and double-buffered updates
// committed only at frame boundaries (or immediately while disabled).
// Optional feature: define SCAN_LZ_BLANK_EN for leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SLOT_CYC  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [VALUE_W-1:0]    i_value_in,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [DIGIT_W-1:0]    o_digit,
  output logic [NIB_W-1:0]      o_nibble,
  output logic                  o_frame_done,
  output logic                  o_upd_pending
);

  localparam int CNT_W = cnt_width(SLOT_CYC);

  logic [CNT_W-1:0]      w_cnt;
  logic                  w_in_blank;
  logic                  w_slot_last;

  scan_state_t           r_state;
  scan_state_t           w_state_nxt;
  digit_t                r_digit;
  digit_t                w_digit_nxt;
  logic [VALUE_W-1:0]    r_active;
  logic [VALUE_W-1:0]    w_active_nxt;
  logic [VALUE_W-1:0]    r_pending;
  logic [VALUE_W-1:0]    w_pending_nxt;
  logic                  r_upd_pending;
  logic                  w_upd_nxt;
  logic [NUM_DIGITS-1:0] r_an;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [NIB_W-1:0]      r_nibble;
  logic [NIB_W-1:0]      w_nibble_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;
  logic                  w_frame_end;
  logic                  w_commit;
  logic                  w_blank_last;
  logic                  w_lit;

  scan_slot_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk         (clk),
    .res         (res),
    .i_en        (i_en),
    .o_cnt       (w_cnt),
    .o_in_blank  (w_in_blank),
    .o_slot_last (w_slot_last)
  );

  assign o_an          = r_an;
  assign o_digit       = r_digit;
  assign o_nibble      = r_nibble;
  assign o_frame_done  = r_frame_done;
  assign o_upd_pending = r_upd_pending;

  // Decide whether the digit about to be shown is allowed to light.
`ifdef SCAN_LZ_BLANK_EN
  assign w_lit = (w_digit_nxt == '0) ||
                 ((w_active_nxt >> {w_digit_nxt, 2'b00}) != '0);
`else
  assign w_lit = 1'b1;
`endif

  // Next-state and next-output decode for the scan FSM and display buffers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_digit_nxt      = r_digit;
    w_active_nxt     = r_active;
    w_pending_nxt    = r_pending;
    w_upd_nxt        = r_upd_pending;

    w_frame_end  = w_slot_last && (r_digit == LAST_DIGIT);
    w_commit     = !i_en || w_frame_end;
    w_blank_last = w_in_blank && (w_cnt == CNT_W'(BLANK_CYC - 1));

    if (!i_en) begin
      w_state_nxt = S_BLANK;
      w_digit_nxt = '0;
    end else if (w_slot_last) begin
      w_state_nxt = S_BLANK;
      w_digit_nxt = r_digit + digit_t'(1);
    end else if (w_blank_last) begin
      w_state_nxt = S_SHOW;
    end

    // A load on a commit edge bypasses the pending buffer and wins over it.
    if (w_commit) begin
      if (i_load) begin
        w_active_nxt = i_value_in;
      end else if (r_upd_pending) begin
        w_active_nxt = r_pending;
      end
      w_upd_nxt = 1'b0;
    end else if (i_load) begin
      w_pending_nxt = i_value_in;
      w_upd_nxt     = 1'b1;
    end

    // Next cycle is the last of digit 3's slot.
    w_frame_done_nxt = i_en && (w_cnt == CNT_W'(SLOT_CYC - 2)) &&
                       (r_digit == LAST_DIGIT);

    w_nibble_nxt = w_active_nxt[{w_digit_nxt, 2'b00} +: NIB_W];
    w_an_nxt     = ((w_state_nxt == S_SHOW) && w_lit) ?
                   anode_decode(w_digit_nxt) : ANODE_OFF;
  end

  // Scan FSM, display buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= S_BLANK;
      r_digit       <= '0;
      r_active      <= '0;
      r_pending     <= '0;
      r_upd_pending <= 1'b0;
      r_an          <= ANODE_OFF;
      r_nibble      <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_digit       <= w_digit_nxt;
      r_active      <= w_active_nxt;
      r_pending     <= w_pending_nxt;
      r_upd_pending <= w_upd_nxt;
      r_an          <= w_an_nxt;
      r_nibble      <= w_nibble_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed testbench for display_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2.
// Honours SCAN_LZ_BLANK_EN when the build defines it.
module tb_display_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        res;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  an;
  logic [1:0]  digit;
  logic [3:0]  nibble;
  logic        frame_done;
  logic        upd_pending;

  int          n_assert;
  int          n_fail;
  int          cyc;
  logic [15:0] exp_act;
  logic [3:0]  low_seen;

  display_scan_ctrl #(
    .SLOT_CYC  (SLOT),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk           (clk),
    .res           (res),
    .i_en          (en),
    .i_load        (load),
    .i_value_in    (value_in),
    .o_an          (an),
    .o_digit       (digit),
    .o_nibble      (nibble),
    .o_frame_done  (frame_done),
    .o_upd_pending (upd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected scan outputs for the current cycle of a running (enabled) frame.
  task automatic chk_scan();
    int         d;
    int         c;
    logic       lit;
    logic [3:0] one;
    logic [3:0] ea;
    d   = (cyc / SLOT) % 4;
    c   = cyc % SLOT;
    one = 4'b0001;
    lit = 1'b1;
`ifdef SCAN_LZ_BLANK_EN
    lit = (d == 0) || ((exp_act >> (4 * d)) != 16'h0);
`endif
    ea = (c < BLANK || !lit) ? 4'hF : ~(one << d);
    check("an", 16'(an), 16'(ea));
    check("digit", 16'(digit), 16'(d));
    check("nibble", 16'(nibble), 16'(exp_act[4 * d +: 4]));
    check("frame_done", 16'(frame_done), 16'((cyc % FRAME) == FRAME - 1));
    low_seen = low_seen | ~an;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      tick();
      chk_scan();
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_act  = 16'h0;
    low_seen = 4'h0;
    res      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 16'(an), 16'hF);
    check("rst_digit", 16'(digit), 16'h0);
    check("rst_nibble", 16'(nibble), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_upd", 16'(upd_pending), 16'h0);

    // Basic scan with a load waiting for the first frame boundary
    res      = 1'b0;
    en       = 1'b1;
    load     = 1'b1;
    value_in = 16'h4321;
    cyc      = 0;
    tick();
    load = 1'b0;
    chk_scan();
    check("upd_after_load", 16'(upd_pending), 16'h1);
    run_to(FRAME - 1);
    check("upd_before_commit", 16'(upd_pending), 16'h1);
    tick();
    exp_act = 16'h4321;
    chk_scan();
    check("upd_after_commit", 16'(upd_pending), 16'h0);
    check("nibble_d0_4321", 16'(nibble), 16'h1);
    run_to(2 * FRAME - 1);

    // Two loads in one frame: last write wins
    run_to(2 * FRAME + 2);
    load     = 1'b1;
    value_in = 16'hAAAA;
    tick();
    chk_scan();
    check("upd_after_aaaa", 16'(upd_pending), 16'h1);
    value_in = 16'hBBBB;
    tick();
    load = 1'b0;
    chk_scan();
    run_to(3 * FRAME - 1);
    check("upd_pending_bbbb", 16'(upd_pending), 16'h1);
    tick();
    exp_act = 16'hBBBB;
    chk_scan();
    check("upd_after_bbbb", 16'(upd_pending), 16'h0);
    check("nibble_bbbb", 16'(nibble), 16'hB);

    // Load in the frame-end cycle overrides an older pending value
    run_to(3 * FRAME + SLOT);
    load     = 1'b1;
    value_in = 16'h1111;
    tick();
    load = 1'b0;
    chk_scan();
    check("upd_pending_1111", 16'(upd_pending), 16'h1);
    run_to(4 * FRAME - 1);
    check("frame_end_seen", 16'(frame_done), 16'h1);
    load     = 1'b1;
    value_in = 16'h5555;
    tick();
    load    = 1'b0;
    exp_act = 16'h5555;
    chk_scan();
    check("upd_after_5555", 16'(upd_pending), 16'h0);
    check("nibble_5555", 16'(nibble), 16'h5);

    // Disable mid-slot with a direct load, then restart from digit 0
    run_to(4 * FRAME + 12);
    check("an_mid_slot", 16'(an), 16'hD);
    en       = 1'b0;
    load     = 1'b1;
    value_in = 16'h0009;
    tick();
    load    = 1'b0;
    exp_act = 16'h0009;
    check("dis_an", 16'(an), 16'hF);
    check("dis_digit", 16'(digit), 16'h0);
    check("dis_nibble", 16'(nibble), 16'h9);
    check("dis_upd", 16'(upd_pending), 16'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("dis_hold_an", 16'(an), 16'hF);
      check("dis_hold_digit", 16'(digit), 16'h0);
      check("dis_hold_fd", 16'(frame_done), 16'h0);
    end
    en  = 1'b1;
    cyc = 0;
    run_to(BLANK);
    check("restart_an", 16'(an), 16'hE);

    // Reset mid-slot in digit 2 with an update pending
    run_to(2 * SLOT + 2);
    load     = 1'b1;
    value_in = 16'h7777;
    tick();
    load = 1'b0;
    chk_scan();
    run_to(2 * SLOT + 4);
    check("pre_rst_an", 16'(an), 16'hB);
    check("pre_rst_upd", 16'(upd_pending), 16'h1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("mid_rst_an", 16'(an), 16'hF);
    check("mid_rst_digit", 16'(digit), 16'h0);
    check("mid_rst_upd", 16'(upd_pending), 16'h0);
    check("mid_rst_nibble", 16'(nibble), 16'h0);
    exp_act = 16'h0;
    cyc     = 0;
    run_to(FRAME);
    check("pending_discarded", 16'(upd_pending), 16'h0);

    // Leading-zero blanking behaviour with active=0070
    en       = 1'b0;
    load     = 1'b1;
    value_in = 16'h0070;
    tick();
    load     = 1'b0;
    en       = 1'b1;
    exp_act  = 16'h0070;
    cyc      = 0;
    low_seen = 4'h0;
    run_to(FRAME - 1);
`ifdef SCAN_LZ_BLANK_EN
    check("lz_digits_lit", 16'(low_seen), 16'h3);
`else
    check("lz_digits_lit", 16'(low_seen), 16'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
